multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 164 ++++++++++++++++
 tb/tb_multicycle_control.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle CPU main control: Moore FSM sequencing fetch/decode/execute/writeback.
// Define MC_MEM_STALL_EN to hold FETCH, MEM_READ and MEM_WRITE until mem_ready.
//
// state     | meaning
// FETCH     | read instruction, load IR, PC <= PC + 1
// DECODE    | register read, precompute branch target, flag illegal opcode
// MEM_ADDR  | ALU computes load/store address
// MEM_READ  | data memory read at ALUOut
// MEM_WB    | write loaded data to register file
// MEM_WRITE | data memory write at ALUOut
// R_EXEC    | ALU operation selected by func
// R_WB      | write ALU result to rd
// BRANCH    | compare and conditionally take branch target
// JUMP      | PC <= jump target
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] ALUop,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_write_not,
  output logic [1:0] pc_source,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_mem_ok;
  logic       w_op_r, w_op_lw, w_op_sw, w_op_beq, w_op_bne, w_op_j, w_op_legal;

  assign w_op_r     = (opcode == 4'b0000);
  assign w_op_lw    = (opcode == 4'b1000);
  assign w_op_sw    = (opcode == 4'b1001);
  assign w_op_beq   = (opcode == 4'b0101);
  assign w_op_bne   = (opcode == 4'b0110);
  assign w_op_j     = (opcode == 4'b1111);
  assign w_op_legal = w_op_r | w_op_lw | w_op_sw | w_op_beq | w_op_bne | w_op_j;

`ifdef MC_MEM_STALL_EN
  assign w_mem_ok = mem_ready;
`else
  // mem_ready is deliberately a don't-care in the single-cycle-memory build
  assign w_mem_ok = mem_ready | 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:     w_next = w_mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_op_lw || w_op_sw)        w_next = S_MEM_ADDR;
        else if (w_op_r)               w_next = S_R_EXEC;
        else if (w_op_beq || w_op_bne) w_next = S_BRANCH;
        else if (w_op_j)               w_next = S_JUMP;
        else                           w_next = S_FETCH;
      end
      S_MEM_ADDR:  w_next = w_op_lw ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  w_next = w_mem_ok ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: w_next = w_mem_ok ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    w_next = S_R_WB;
      default:     w_next = S_FETCH;
    endcase
  end

  // Outputs are forced low while rst_n is low, since r_state alone would show FETCH strobes.
  always_comb begin
    ALUop         = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_write_not  = 1'b0;
    pc_source     = 2'b00;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_op    = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = w_mem_ok;
          pc_write  = w_mem_ok;
          alu_src_b = 2'b01;
        end
        S_DECODE: begin
          alu_src_b  = 2'b11;
          illegal_op = ~w_op_legal;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          ALUop     = 2'b10;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          ALUop         = 2'b01;
          pc_source     = 2'b01;
          pc_write_cond = w_op_beq;
          pc_write_not  = w_op_bne;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus random instruction stream
// checked cycle by cycle against a path/table reference model.
module tb_multicycle_control;

  typedef struct packed {
    logic [1:0] aluop;
    logic       src_a;
    logic [1:0] src_b;
    logic       pcw, pcwc, pcwn;
    logic [1:0] pcsrc;
    logic       irw, mrd, mwr, iord, rw, rdst, m2r, ill;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       mem_ready;
  logic [1:0] ALUop;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_write, pc_write_cond, pc_write_not;
  logic [1:0] pc_source;
  logic       ir_write, mem_read, mem_write, i_or_d;
  logic       reg_write, reg_dst, mem_to_reg, illegal_op;
  logic [3:0] state;

  int n_total = 0;
  int n_bad   = 0;

  outs_t obs;
  assign obs = {ALUop, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_write_not, pc_source,
                ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg, illegal_op};

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .ALUop(ALUop), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_write_not(pc_write_not),
    .pc_source(pc_source), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction path as the list of states visited, from the opcode table and latency rules.
  task automatic path_of(input logic [3:0] op, output int p[$]);
    case (op)
      4'b0000:          p = '{0, 1, 6, 7};
      4'b1000:          p = '{0, 1, 2, 3, 4};
      4'b1001:          p = '{0, 1, 2, 5};
      4'b0101, 4'b0110: p = '{0, 1, 8};
      4'b1111:          p = '{0, 1, 9};
      default:          p = '{0, 1};
    endcase
  endtask

  function automatic outs_t exp_out(input int st, input logic [3:0] op, input logic mr);
    outs_t o;
    logic  gate;
    o = '0;
`ifdef MC_MEM_STALL_EN
    gate = mr;
`else
    gate = 1'b1;
`endif
    case (st)
      0: begin o.mrd = 1; o.irw = gate; o.pcw = gate; o.src_b = 2'b01; end
      1: begin
        o.src_b = 2'b11;
        o.ill = !(op inside {4'b0000, 4'b1000, 4'b1001, 4'b0101, 4'b0110, 4'b1111});
      end
      2: begin o.src_a = 1; o.src_b = 2'b10; end
      3: begin o.mrd = 1; o.iord = 1; end
      4: begin o.rw = 1; o.m2r = 1; end
      5: begin o.mwr = 1; o.iord = 1; end
      6: begin o.src_a = 1; o.aluop = 2'b10; end
      7: begin o.rw = 1; o.rdst = 1; end
      8: begin
        o.src_a = 1; o.aluop = 2'b01; o.pcsrc = 2'b01;
        o.pcwc = (op == 4'b0101); o.pcwn = (op == 4'b0110);
      end
      9: begin o.pcw = 1; o.pcsrc = 2'b10; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Starts and ends at a falling edge with the DUT in FETCH.
  task automatic run_instr(input string name, input logic [3:0] op, input int fetch_hold, input bit rnd);
    int   p[$];
    int   idx = 0;
    int   held = 0;
    int   cur;
    logic mr;
    bit   stall;
    path_of(op, p);
    while (idx < p.size()) begin
      cur = p[idx];
      if (idx == 0 && fetch_hold > 0) begin
        mr = 1'b0;
        fetch_hold--;
      end else if (rnd && held < 3) mr = ($urandom_range(0, 2) != 0);
      else mr = 1'b1;
      opcode    = op;
      mem_ready = mr;
      #1;
      check({name, "_state"}, state, cur);
      check({name, "_outs"}, obs, exp_out(cur, op, mr));
      check({name, "_cond_not_excl"}, pc_write_cond & pc_write_not, 0);
`ifdef MC_MEM_STALL_EN
      stall = !mr && (cur == 0 || cur == 3 || cur == 5);
`else
      stall = 1'b0;
`endif
      if (stall) held++;
      else begin
        idx++;
        held = 0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0] rop;
    rst_n = 1'b0;
    opcode = 4'b0000;
    mem_ready = 1'b1;
    #3;
    check("reset_state", state, 0);
    check("reset_outs", obs, 0);
    repeat (2) @(negedge clk);
    check("reset_outs_after_edges", obs, 0);
    rst_n = 1'b1;

    run_instr("lw", 4'b1000, 0, 0);
    run_instr("rtype", 4'b0000, 0, 0);
    run_instr("bne", 4'b0110, 0, 0);
    run_instr("illegal", 4'b0011, 0, 0);
    run_instr("beq", 4'b0101, 0, 0);
    run_instr("jump", 4'b1111, 0, 0);
    run_instr("sw", 4'b1001, 0, 0);

    // Reset dropped in MEM_WRITE of a store.
    opcode = 4'b1001;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_pre_state", state, 5);
    check("rst_pre_mem_write", mem_write, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_state", state, 0);
    check("rst_async_mem_write", mem_write, 0);
    check("rst_async_outs", obs, 0);
    @(posedge clk);
    #1;
    check("rst_held_outs", obs, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_state", state, 0);
    check("rst_release_pc_write", pc_write, 1);
    @(posedge clk);
    #1;
    check("rst_first_edge_fetch", state, 1);
    repeat (4) @(negedge clk);
    check("rst_sw_done", state, 0);

    run_instr("lw_fetch_stall", 4'b1000, 2, 0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) rop = 4'($urandom_range(0, 15));
      else begin
        case ($urandom_range(0, 5))
          0: rop = 4'b0000;
          1: rop = 4'b1000;
          2: rop = 4'b1001;
          3: rop = 4'b0101;
          4: rop = 4'b0110;
          default: rop = 4'b1111;
        endcase
      end
      run_instr("rand", rop, 0, 1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
